// File: rtl/spi_bridge_pkg.sv
// Shared types and constants for the SPI slave to register bridge.
package spi_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR       = 3'd1,
    ST_RD_FETCH = 3'd2,
    ST_RD_LOAD  = 3'd3,
    ST_RD_WAIT  = 3'd4
  } state_e;

  localparam int CMD_RD_BIT    = 7;
  localparam int CMD_ADDR_BITS = 7;

  // Wider than any supported word; users slice it down to their word width.
  localparam logic [31:0] TX_IDLE = '1;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/spi_slave_reg_bridge.sv
// Decodes SPI frames (command byte + data) into auto-incrementing register
// writes or prefetched reads, feeding read data back to the slave's TX input.
module spi_slave_reg_bridge
  import spi_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  en_i,
  input  logic                  spi_rdy_i,
  output logic                  spi_rdy_ack_o,
  input  logic [DATA_WIDTH-1:0] spi_data_i,
  input  logic                  spi_first_byte_i,
  input  logic                  spi_last_byte_i,
  output logic                  spi_last_byte_ack_o,
  output logic [DATA_WIDTH-1:0] spi_tx_data_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic                  mem_we_o,
  output logic                  mem_re_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic [7:0]            byte_cnt_o
);

  typedef struct packed {
    state_e                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] tx;
    logic                  we;
    logic                  re;
    logic [7:0]            cnt;
    logic [7:0]            byte_cnt;
    logic                  ack;
    logic                  last_ack;
  } regs_t;

  localparam regs_t REGS_RST = '{
    state:    ST_IDLE,
    addr:     '0,
    mem_addr: '0,
    wdata:    '0,
    tx:       TX_IDLE[DATA_WIDTH-1:0],
    we:       1'b0,
    re:       1'b0,
    cnt:      8'd0,
    byte_cnt: 8'd0,
    ack:      1'b0,
    last_ack: 1'b0
  };

  regs_t q, d;

  logic                  live;
  logic                  fetch_phase;
  logic                  word_acc;
  logic                  frame_end;
  logic                  cmd_rd;
  logic [ADDR_WIDTH-1:0] cmd_addr;

  assign live        = en_i && rst_n_i;
  assign fetch_phase = (q.state == ST_RD_FETCH) || (q.state == ST_RD_LOAD);

  // The slave's rdy falls a cycle after our ack, so the cycle after an ack is
  // blanked. Mid-prefetch only a new command may be taken (resync).
  assign word_acc  = live && spi_rdy_i && !q.ack && (!fetch_phase || spi_first_byte_i);
  // A pending word always wins; frame end waits until no prefetch is in flight.
  assign frame_end = live && spi_last_byte_i && !spi_rdy_i && !q.last_ack && !fetch_phase;

  assign cmd_rd   = spi_data_i[CMD_RD_BIT];
  assign cmd_addr = ADDR_WIDTH'(spi_data_i[CMD_ADDR_BITS-1:0]);

  always_comb begin
    // NOTE: every field gets a default from q first, so no path leaves a latch.
    d          = q;
    d.we       = 1'b0;
    d.re       = 1'b0;
    d.ack      = word_acc;
    d.last_ack = frame_end;

    if (word_acc) begin
      d.cnt = sat_inc8(q.cnt);
      if (spi_first_byte_i) begin
        d.addr = cmd_addr;
        if (cmd_rd) begin
          d.state    = ST_RD_FETCH;
          d.re       = 1'b1;
          d.mem_addr = cmd_addr;
        end else begin
          d.state = ST_WR;
          d.tx    = TX_IDLE[DATA_WIDTH-1:0];
        end
      end else begin
        case (q.state)
          ST_WR: begin
            d.we       = 1'b1;
            d.mem_addr = q.addr;
            d.wdata    = spi_data_i;
            d.addr     = q.addr + ADDR_WIDTH'(1);
          end
          ST_RD_WAIT: begin
            d.state    = ST_RD_FETCH;
            d.re       = 1'b1;
            d.mem_addr = q.addr;
          end
          default: ;
        endcase
      end
    end else if (frame_end) begin
      d.state    = ST_IDLE;
      d.tx       = TX_IDLE[DATA_WIDTH-1:0];
      d.byte_cnt = q.cnt;
      d.cnt      = 8'd0;
    end else begin
      case (q.state)
        ST_RD_FETCH: d.state = ST_RD_LOAD;
        ST_RD_LOAD: begin
          d.tx    = mem_rdata_i;
          d.addr  = q.addr + ADDR_WIDTH'(1);
          d.state = ST_RD_WAIT;
        end
        default: ;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments only.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      q <= REGS_RST;
    end else if (!en_i) begin
      q <= REGS_RST;
    end else begin
      q <= d;
    end
  end

  assign spi_rdy_ack_o       = word_acc;
  assign spi_last_byte_ack_o = frame_end;
  assign frame_done_o        = frame_end;
  assign spi_tx_data_o       = q.tx;
  assign mem_addr_o          = q.mem_addr;
  assign mem_wdata_o         = q.wdata;
  assign mem_we_o            = q.we;
  assign mem_re_o            = q.re;
  assign busy_o              = (q.state != ST_IDLE);
  assign byte_cnt_o          = q.byte_cnt;

endmodule

// File: tb/tb_spi_slave_reg_bridge.sv
// Self-checking bench: drives SPI-slave-style words/frame ends and compares
// memory traffic, MISO data and frame counts against a simple memory model.
module tb_spi_slave_reg_bridge;

  localparam int DEPTH = 128;

  logic       clk_i = 1'b0;
  logic       rst_n_i, en_i, spi_rdy_i, spi_first_byte_i, spi_last_byte_i;
  logic [7:0] spi_data_i;
  logic [7:0] mem_rdata_i;
  logic       spi_rdy_ack_o, spi_last_byte_ack_o, mem_we_o, mem_re_o, busy_o, frame_done_o;
  logic [7:0] spi_tx_data_o, mem_wdata_o, byte_cnt_o;
  logic [6:0] mem_addr_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  spi_slave_reg_bridge #(.ADDR_WIDTH(7), .DATA_WIDTH(8)) dut (
    .clk_i               (clk_i),
    .rst_n_i             (rst_n_i),
    .en_i                (en_i),
    .spi_rdy_i           (spi_rdy_i),
    .spi_rdy_ack_o       (spi_rdy_ack_o),
    .spi_data_i          (spi_data_i),
    .spi_first_byte_i    (spi_first_byte_i),
    .spi_last_byte_i     (spi_last_byte_i),
    .spi_last_byte_ack_o (spi_last_byte_ack_o),
    .spi_tx_data_o       (spi_tx_data_o),
    .mem_addr_o          (mem_addr_o),
    .mem_wdata_o         (mem_wdata_o),
    .mem_we_o            (mem_we_o),
    .mem_re_o            (mem_re_o),
    .mem_rdata_i         (mem_rdata_i),
    .busy_o              (busy_o),
    .frame_done_o        (frame_done_o),
    .byte_cnt_o          (byte_cnt_o)
  );

  // Synchronous memory attached to the bridge: read data one cycle after re.
  logic [7:0] mem [DEPTH];
  always @(posedge clk_i) begin
    if (mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
    if (mem_re_o) mem_rdata_i <= mem[mem_addr_o];
  end

  // Reference model: what memory must hold according to the frames sent.
  logic [7:0] ref_mem [DEPTH];
  logic [7:0] frame_buf [300];
  int         got_tx [$];

  // Passive monitor, sampled on the falling edge.
  int   ack_cnt = 0, lack_cnt = 0, done_cnt = 0, viol_cnt = 0;
  logic prev_ack = 1'b0;
  int   wr_addr_q [$];
  int   wr_data_q [$];
  int   re_addr_q [$];
  time  we_time = 0, lack_time = 0;

  always @(negedge clk_i) begin
    if (spi_rdy_ack_o) ack_cnt++;
    if (spi_rdy_ack_o && prev_ack) viol_cnt++;
    if (spi_rdy_ack_o && spi_last_byte_ack_o) viol_cnt++;
    if (spi_last_byte_ack_o) begin lack_cnt++; lack_time = $time; end
    if (frame_done_o) done_cnt++;
    if (mem_we_o) begin
      wr_addr_q.push_back(int'(mem_addr_o));
      wr_data_q.push_back(int'(mem_wdata_o));
      we_time = $time;
    end
    if (mem_re_o) re_addr_q.push_back(int'(mem_addr_o));
    prev_ack = spi_rdy_ack_o;
  end

  function automatic int mem_mismatches();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  // ---------------- drivers ----------------
  task automatic send_word(input logic [7:0] data, input logic first, input logic last);
    bit seen = 0;
    @(posedge clk_i); #1;
    spi_data_i = data; spi_first_byte_i = first; spi_last_byte_i = last; spi_rdy_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      if (spi_rdy_ack_o) begin seen = 1; break; end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL word_ack: no spi_rdy_ack_o within 8 cycles for word %h", data);
    end
    // Slave's rdy stays high through the blanking cycle, then drops.
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    spi_rdy_i = 1'b0; spi_first_byte_i = 1'b0;
  endtask

  task automatic end_frame();
    bit seen = 0;
    @(posedge clk_i); #1;
    spi_last_byte_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      if (spi_last_byte_ack_o) begin seen = 1; break; end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL frame_end_ack: no spi_last_byte_ack_o within 8 cycles");
    end
    @(posedge clk_i); #1;
    spi_last_byte_i = 1'b0;
  endtask

  task automatic write_frame(input logic [6:0] a, input int n, input bit do_end);
    send_word({1'b0, a}, 1'b1, 1'b0);
    for (int i = 0; i < n; i++) begin
      repeat (3) @(posedge clk_i);
      send_word(frame_buf[i], 1'b0, 1'b0);
      ref_mem[(int'(a) + i) % DEPTH] = frame_buf[i];
    end
    if (do_end) begin
      repeat (3) @(posedge clk_i);
      end_frame();
    end
  endtask

  // Samples MISO before each dummy word: n dummies return n bytes.
  task automatic read_frame(input logic [6:0] a, input int n);
    send_word({1'b1, a}, 1'b1, 1'b0);
    for (int k = 0; k < n; k++) begin
      repeat (5) @(posedge clk_i);
      @(negedge clk_i);
      got_tx.push_back(int'(spi_tx_data_o));
      send_word(8'($urandom), 1'b0, 1'b0);
    end
    repeat (5) @(posedge clk_i);
    end_frame();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n_i = 1'b0; en_i = 1'b1;
    spi_rdy_i = 1'b1; spi_last_byte_i = 1'b1; spi_first_byte_i = 1'b1; spi_data_i = 8'h00;
    repeat (3) @(negedge clk_i);
    checks++; if (spi_tx_data_o !== 8'hFF) begin errors++; $display("FAIL reset_tx: got %h want ff", spi_tx_data_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    checks++; if (byte_cnt_o !== 8'd0) begin errors++; $display("FAIL reset_byte_cnt: got %0d want 0", byte_cnt_o); end
    checks++;
    if ({mem_we_o, mem_re_o, spi_rdy_ack_o, spi_last_byte_ack_o, frame_done_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes: got we=%b re=%b ack=%b lack=%b done=%b want all 0",
               mem_we_o, mem_re_o, spi_rdy_ack_o, spi_last_byte_ack_o, frame_done_o);
    end
    spi_rdy_i = 1'b0; spi_last_byte_i = 1'b0; spi_first_byte_i = 1'b0;
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
  endtask

  task automatic test_fill();
    int wb = wr_addr_q.size();
    for (int i = 0; i < DEPTH; i++) frame_buf[i] = 8'($urandom);
    write_frame(7'h00, DEPTH, 1'b1);
    @(negedge clk_i);
    checks++; if (wr_addr_q.size() - wb != DEPTH) begin errors++; $display("FAIL fill_writes: got %0d want %0d", wr_addr_q.size() - wb, DEPTH); end
    checks++; if (mem_mismatches() != 0) begin errors++; $display("FAIL fill_mem: %0d entries differ, want 0", mem_mismatches()); end
    checks++; if (byte_cnt_o !== 8'd129) begin errors++; $display("FAIL fill_byte_cnt: got %0d want 129", byte_cnt_o); end
  endtask

  task automatic test_write_burst();
    int wb = wr_addr_q.size();
    int db = done_cnt;
    frame_buf[0] = 8'hAA; frame_buf[1] = 8'hBB;
    write_frame(7'h05, 2, 1'b1);
    @(negedge clk_i);
    checks++;
    if (wr_addr_q.size() - wb != 2 || wr_addr_q[wb] != 5 || wr_data_q[wb] != 'hAA ||
        wr_addr_q[wb+1] != 6 || wr_data_q[wb+1] != 'hBB) begin
      errors++; $display("FAIL wr_burst_seq: got %0d writes, want [5]=aa [6]=bb", wr_addr_q.size() - wb);
    end
    checks++; if (mem[5] !== 8'hAA || mem[6] !== 8'hBB) begin errors++; $display("FAIL wr_burst_mem: got %h %h want aa bb", mem[5], mem[6]); end
    checks++; if (byte_cnt_o !== 8'd3) begin errors++; $display("FAIL wr_burst_byte_cnt: got %0d want 3", byte_cnt_o); end
    checks++; if (done_cnt - db != 1) begin errors++; $display("FAIL wr_burst_done: got %0d pulses want 1", done_cnt - db); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL wr_burst_idle: busy got %b want 0", busy_o); end
  endtask

  task automatic test_read_burst();
    int gb, rb;
    frame_buf[0] = 8'h11; frame_buf[1] = 8'h22; frame_buf[2] = 8'h33;
    write_frame(7'h10, 3, 1'b1);
    gb = got_tx.size(); rb = re_addr_q.size();
    read_frame(7'h10, 3);
    @(negedge clk_i);
    checks++;
    if (got_tx[gb] != 'h11 || got_tx[gb+1] != 'h22 || got_tx[gb+2] != 'h33) begin
      errors++; $display("FAIL rd_burst_miso: got %h %h %h want 11 22 33", got_tx[gb], got_tx[gb+1], got_tx[gb+2]);
    end
    checks++;
    if (re_addr_q.size() - rb != 4 || re_addr_q[rb] != 'h10 || re_addr_q[rb+3] != 'h13) begin
      errors++; $display("FAIL rd_burst_re: got %0d reads want 4 at 10..13", re_addr_q.size() - rb);
    end
    checks++; if (byte_cnt_o !== 8'd4) begin errors++; $display("FAIL rd_burst_byte_cnt: got %0d want 4", byte_cnt_o); end
    checks++; if (spi_tx_data_o !== 8'hFF) begin errors++; $display("FAIL rd_burst_tx_idle: got %h want ff", spi_tx_data_o); end
  endtask

  task automatic test_wrap();
    int gb;
    frame_buf[0] = 8'h01; frame_buf[1] = 8'h02;
    write_frame(7'h7F, 2, 1'b1);
    @(negedge clk_i);
    checks++; if (mem[127] !== 8'h01 || mem[0] !== 8'h02) begin errors++; $display("FAIL wrap_write: got %h %h want 01 02", mem[127], mem[0]); end
    gb = got_tx.size();
    read_frame(7'h7E, 3);
    checks++;
    if (got_tx[gb] != int'(ref_mem[126]) || got_tx[gb+1] != 'h01 || got_tx[gb+2] != 'h02) begin
      errors++; $display("FAIL wrap_read: got %h %h %h want %h 01 02", got_tx[gb], got_tx[gb+1], got_tx[gb+2], ref_mem[126]);
    end
  endtask

  task automatic test_handshake();
    int ab = ack_cnt;
    int wb = wr_addr_q.size();
    frame_buf[0] = 8'h5C;
    write_frame(7'h08, 1, 1'b1);
    @(negedge clk_i);
    checks++; if (ack_cnt - ab != 2) begin errors++; $display("FAIL hs_acks: got %0d want 2", ack_cnt - ab); end
    checks++; if (wr_addr_q.size() - wb != 1) begin errors++; $display("FAIL hs_writes: got %0d want 1", wr_addr_q.size() - wb); end
    checks++; if (viol_cnt != 0) begin errors++; $display("FAIL hs_protocol: %0d ack violations want 0", viol_cnt); end
  endtask

  task automatic test_simultaneous();
    bit seen = 0;
    frame_buf[0] = 8'hC3;
    write_frame(7'h20, 1, 1'b0);
    repeat (3) @(posedge clk_i);
    send_word(8'h3C, 1'b0, 1'b1);
    ref_mem[8'h21] = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      if (spi_last_byte_ack_o) begin seen = 1; break; end
    end
    checks++; if (!seen) begin errors++; $display("FAIL simul_frame_end: no last-byte ack within 8 cycles"); end
    @(posedge clk_i); #1;
    spi_last_byte_i = 1'b0;
    @(negedge clk_i);
    checks++; if (mem[8'h21] !== 8'h3C) begin errors++; $display("FAIL simul_write: got %h want 3c", mem[8'h21]); end
    checks++; if (!(we_time < lack_time)) begin errors++; $display("FAIL simul_order: write at %0t, frame end at %0t", we_time, lack_time); end
    checks++; if (byte_cnt_o !== 8'd3) begin errors++; $display("FAIL simul_byte_cnt: got %0d want 3", byte_cnt_o); end
  endtask

  task automatic test_resync();
    int gb;
    frame_buf[0] = 8'($urandom);
    write_frame(7'h50, 1, 1'b0);
    gb = got_tx.size();
    read_frame(7'h50, 2);
    @(negedge clk_i);
    checks++;
    if (got_tx[gb] != int'(ref_mem[8'h50]) || got_tx[gb+1] != int'(ref_mem[8'h51])) begin
      errors++; $display("FAIL resync_read: got %h %h want %h %h", got_tx[gb], got_tx[gb+1], ref_mem[8'h50], ref_mem[8'h51]);
    end
    checks++; if (byte_cnt_o !== 8'd5) begin errors++; $display("FAIL resync_byte_cnt: got %0d want 5", byte_cnt_o); end
  endtask

  task automatic test_empty_frame_end();
    int db = done_cnt;
    end_frame();
    @(negedge clk_i);
    checks++; if (byte_cnt_o !== 8'd0) begin errors++; $display("FAIL empty_byte_cnt: got %0d want 0", byte_cnt_o); end
    checks++; if (done_cnt - db != 1) begin errors++; $display("FAIL empty_done: got %0d pulses want 1", done_cnt - db); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 259; i++) frame_buf[i] = 8'($urandom);
    write_frame(7'h40, 259, 1'b1);
    @(negedge clk_i);
    checks++; if (byte_cnt_o !== 8'd255) begin errors++; $display("FAIL sat_byte_cnt: got %0d want 255", byte_cnt_o); end
    checks++; if (mem_mismatches() != 0) begin errors++; $display("FAIL sat_mem: %0d entries differ, want 0", mem_mismatches()); end
  endtask

  task automatic test_random();
    logic [6:0] a;
    int n, wb, rb, gb, bad;
    for (int it = 0; it < 16; it++) begin
      a = 7'($urandom_range(0, 127));
      n = $urandom_range(1, 6);
      bad = 0;
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < n; i++) frame_buf[i] = 8'($urandom);
        wb = wr_addr_q.size();
        write_frame(a, n, 1'b1);
        @(negedge clk_i);
        if (wr_addr_q.size() - wb != n) bad++;
        else for (int i = 0; i < n; i++)
          if (wr_addr_q[wb+i] != (int'(a) + i) % DEPTH || wr_data_q[wb+i] != int'(frame_buf[i])) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL rand_wr_seq: iter %0d addr %h len %0d, %0d bad writes", it, a, n, bad); end
        checks++; if (mem_mismatches() != 0) begin errors++; $display("FAIL rand_wr_mem: iter %0d, %0d entries differ", it, mem_mismatches()); end
      end else begin
        rb = re_addr_q.size(); gb = got_tx.size();
        read_frame(a, n);
        @(negedge clk_i);
        for (int k = 0; k < n; k++) if (got_tx[gb+k] != int'(ref_mem[(int'(a) + k) % DEPTH])) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL rand_rd_miso: iter %0d addr %h len %0d, %0d wrong bytes", it, a, n, bad); end
        bad = 0;
        if (re_addr_q.size() - rb != n + 1) bad++;
        else for (int k = 0; k <= n; k++) if (re_addr_q[rb+k] != (int'(a) + k) % DEPTH) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL rand_rd_re: iter %0d addr %h, %0d bad read strobes", it, a, bad); end
      end
      checks++; if (int'(byte_cnt_o) != n + 1) begin errors++; $display("FAIL rand_byte_cnt: iter %0d got %0d want %0d", it, byte_cnt_o, n + 1); end
    end
  endtask

  task automatic test_reset_mid_frame();
    send_word(8'h90, 1'b1, 1'b0);
    repeat (5) @(posedge clk_i);
    send_word(8'h00, 1'b0, 1'b0);
    rst_n_i = 1'b0;
    @(negedge clk_i);
    checks++; if (spi_tx_data_o !== 8'hFF) begin errors++; $display("FAIL rst_mid_tx: got %h want ff", spi_tx_data_o); end
    checks++; if (busy_o !== 1'b0 || mem_re_o !== 1'b0) begin errors++; $display("FAIL rst_mid_state: busy %b re %b want 0 0", busy_o, mem_re_o); end
    checks++; if (byte_cnt_o !== 8'd0) begin errors++; $display("FAIL rst_mid_byte_cnt: got %0d want 0", byte_cnt_o); end
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    frame_buf[0] = 8'h5A; frame_buf[1] = 8'hA5;
    write_frame(7'h30, 2, 1'b1);
    @(negedge clk_i);
    checks++; if (mem[8'h30] !== 8'h5A || mem[8'h31] !== 8'hA5) begin errors++; $display("FAIL rst_mid_next: got %h %h want 5a a5", mem[8'h30], mem[8'h31]); end
    checks++; if (byte_cnt_o !== 8'd3) begin errors++; $display("FAIL rst_mid_next_cnt: got %0d want 3", byte_cnt_o); end
  endtask

  task automatic test_enable_mid_frame();
    frame_buf[0] = 8'h77;
    write_frame(7'h60, 1, 1'b0);
    @(posedge clk_i); #1;
    en_i = 1'b0; spi_rdy_i = 1'b1; spi_data_i = 8'h99;
    @(negedge clk_i);
    checks++; if (spi_rdy_ack_o !== 1'b0) begin errors++; $display("FAIL en_ack: got %b want 0", spi_rdy_ack_o); end
    @(negedge clk_i);
    checks++; if (busy_o !== 1'b0 || spi_tx_data_o !== 8'hFF || byte_cnt_o !== 8'd0) begin
      errors++; $display("FAIL en_clear: busy %b tx %h cnt %0d want 0 ff 0", busy_o, spi_tx_data_o, byte_cnt_o);
    end
    spi_rdy_i = 1'b0; en_i = 1'b1;
    frame_buf[0] = 8'h12; frame_buf[1] = 8'h34;
    write_frame(7'h61, 2, 1'b1);
    @(negedge clk_i);
    checks++; if (mem_mismatches() != 0) begin errors++; $display("FAIL en_next_mem: %0d entries differ", mem_mismatches()); end
    checks++; if (byte_cnt_o !== 8'd3) begin errors++; $display("FAIL en_next_cnt: got %0d want 3", byte_cnt_o); end
    checks++; if (viol_cnt != 0) begin errors++; $display("FAIL protocol_total: %0d ack violations want 0", viol_cnt); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_write_burst();
    test_read_burst();
    test_wrap();
    test_handshake();
    test_simultaneous();
    test_resync();
    test_empty_frame_end();
    test_saturation();
    test_random();
    test_reset_mid_frame();
    test_enable_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/spi_slave_reg_bridge.md
# spi_slave_reg_bridge

Byte-to-register bridge sitting directly downstream of the SPI slave core. It consumes received words through the slave's ready/acknowledge handshake and decodes the first byte of each frame as a command (read/write plus start address). It then turns the following bytes into auto-incrementing writes or prefetched reads on a simple synchronous memory port, and supplies read data back to the slave's transmit input.

## Interface
- `ADDR_WIDTH`, default 7: memory address width. The command byte carries 7 address bits; the upper bits are zero-extended.
- `DATA_WIDTH`, default 8: word width. It must equal the SPI slave's `MAX_BITS_PER_WORD`.
- `clk_i`  in  1  system clock. This is the only clock.
- `rst_n_i`  in  1  reset, asynchronous, active-low.
- `en_i`  in  1  enable. Low acts as a synchronous clear to IDLE with reset values.
- `spi_rdy_i`  in  1  received word pending; connects to the slave's `rdy_o`.
- `spi_rdy_ack_o`  out  1  one-cycle acknowledge of `spi_rdy_i`.
- `spi_data_i`  in  DATA_WIDTH  received word; stable while `spi_rdy_i` is high.
- `spi_first_byte_i`  in  1  high when the pending word is the first of the frame.
- `spi_last_byte_i`  in  1  frame-end (SS rise) pending.
- `spi_last_byte_ack_o`  out  1  one-cycle acknowledge of `spi_last_byte_i`.
- `spi_tx_data_o`  out  DATA_WIDTH  next word to transmit; connects to the slave's `bus_i`.
- `mem_addr_o`  out  ADDR_WIDTH  memory address.
- `mem_wdata_o`  out  DATA_WIDTH  write data.
- `mem_we_o`  out  1  write strobe, one cycle per word.
- `mem_re_o`  out  1  read strobe, one cycle.
- `mem_rdata_i`  in  DATA_WIDTH  read data, valid exactly 1 cycle after `mem_re_o`.
- `busy_o`  out  1  frame in progress (state is not IDLE).
- `frame_done_o`  out  1  one-cycle pulse on frame end.
- `byte_cnt_o`  out  8  number of words in the last completed frame, saturating at 255.

## Operation
- Command byte format: bit7 = R/nW (1 = read); bits6:0 = start address.
- States:
  - IDLE: wait for a frame.
  - WR: each data word is written.
  - RD_FETCH: issue the read.
  - RD_LOAD: capture read data.
  - RD_WAIT: wait for the next dummy word.
- Accepting a word: a word is accepted when `spi_rdy_i`=1 and no ack was issued in the previous cycle. The slave's ready output is registered and falls one cycle late, so the cycle after an ack is a blanking cycle. On acceptance, pulse `spi_rdy_ack_o`, latch `spi_data_i`, and increment the frame byte counter.
- Command decode: an accepted word with `spi_first_byte_i`=1 is always decoded as a command, from any state (resync). Decode loads `addr` = bits6:0.
  - bit7=0 -> WR.
  - bit7=1 -> RD_FETCH.
- WR: each accepted word produces `mem_we_o`=1 with `mem_addr_o`=addr and `mem_wdata_o`=word; then addr+1.
- Reads:
  - RD_FETCH: `mem_re_o`=1 at addr; go to RD_LOAD.
  - RD_LOAD: `spi_tx_data_o` <= `mem_rdata_i`; addr+1; go to RD_WAIT.
  - RD_WAIT: each accepted (dummy) word -> RD_FETCH.
  - The word returned in SPI byte k+1 is mem[start+k].
- Address wrap: addr increments modulo 2^ADDR_WIDTH (all-ones -> 0), silently.
- Idle TX value: `spi_tx_data_o` = all-ones in IDLE, WR, and after a frame end.
- Frame end: when `spi_last_byte_i`=1 and no word is pending:
  - pulse `spi_last_byte_ack_o` and `frame_done_o`;
  - copy the byte counter to `byte_cnt_o` and clear the counter;
  - go to IDLE.
- Simultaneous word and frame end: the pending word is processed first; frame end is handled on a later cycle. A frame end arriving in RD_FETCH/RD_LOAD waits until RD_WAIT.
- Frame end in IDLE with no bytes: acknowledge it, set `byte_cnt_o`=0, pulse `frame_done_o`.

## Timing
- Reset values (reset or `en_i`=0):
  - state IDLE, addr 0;
  - all strobes, acks and `frame_done_o` 0;
  - `spi_tx_data_o` all-ones, `byte_cnt_o` 0, `busy_o` 0.
- Let cycle 0 be the cycle a word is accepted (ack high).
  - Write: `mem_we_o` at cycle 1.
  - Read: `mem_re_o` at cycle 1, `spi_tx_data_o` updated at cycle 3.
- System requirement: clk_i ≥ 16× SCK. This covers the slave's 2-cycle rdy sync plus 3 cycles, within half an SCK period before the next word's TX load.
- `spi_rdy_ack_o` never asserts on two consecutive cycles. `spi_last_byte_ack_o` never asserts in the same cycle as `spi_rdy_ack_o`.
- The counter update (latched into `byte_cnt_o`) and `frame_done_o` occur in the ack cycle of frame end.
- Reset mid-frame: immediate return to reset values. The next frame is decoded normally from its first byte.

## Structure
- Shared package `spi_bridge_pkg` holds:
  - state encoding (typedef);
  - `CMD_RD_BIT`=7;
  - `CMD_ADDR_BITS`=7;
  - `TX_IDLE` (all-ones).
- Single module; no sub-module. Blanking and frame-end arbitration stay inline.

## Test plan
- Write burst: frame 0x05,0xAA,0xBB, SS high -> writes mem[5]=0xAA, mem[6]=0xBB; `byte_cnt_o`=3; one `frame_done_o` pulse.
- Read burst: mem[0x10..0x12]=0x11,0x22,0x33; frame 0x90 plus 3 dummies -> MISO returns 0x11,0x22,0x33 in bytes 2-4; `mem_re_o` pulses at 0x10..0x13.
- Wrap: write frame 0x7F,0x01,0x02 -> mem[0x7F]=0x01, mem[0x00]=0x02.
- Handshake: hold `spi_rdy_i` high for 3 cycles after a single word -> exactly one ack pulse; no double write.
- Simultaneous word and frame end: last word and `spi_last_byte_i` in the same cycle -> word written first, frame-end ack follows, `byte_cnt_o` correct.
- Reset/enable mid-frame: `rst_n_i` low during a read burst -> outputs at reset values, `spi_tx_data_o`=0xFF; the following write frame executes correctly.
